// File: rtl/vx_gpr_bank_req.sv
// Banked GPR operand-read sequencer: maps each masked source operand to a bank,
// serialises bank conflicts, merges identical registers and returns one response.
//   state | meaning
//   IDLE  | waiting for a request (req_ready=1)
//   ISSUE | one read per bank per cycle until every masked slot is issued
//   WAIT  | capture read data for the last issue cycle
//   RSP   | response held until rsp_ready
module vx_gpr_bank_req #(
  parameter int NUM_SRCS   = 3,
  parameter int NUM_BANKS  = 2,
  parameter int NR_BITS    = 6,
  parameter int WID_W      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        req_valid,
  input  logic [WID_W-1:0]                            req_wid,
  input  logic [NUM_SRCS*NR_BITS-1:0]                 req_rs,
  input  logic [NUM_SRCS-1:0]                         req_mask,
  output logic                                        req_ready,
  output logic [NUM_BANKS-1:0]                        bank_valid,
  output logic [NUM_BANKS*WID_W-1:0]                  bank_wid,
  output logic [NUM_BANKS*(NR_BITS-$clog2(NUM_BANKS))-1:0] bank_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]             bank_rdata,
  output logic                                        rsp_valid,
  output logic [WID_W-1:0]                            rsp_wid,
  output logic [NUM_SRCS*DATA_WIDTH-1:0]              rsp_data,
  input  logic                                        rsp_ready
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int AW        = NR_BITS - BANK_BITS;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;

  state_t                         state, state_nxt;
  logic [WID_W-1:0]               wid_q;
  logic [NUM_SRCS*NR_BITS-1:0]    rs_q;
  logic [NUM_SRCS-1:0]            pending, pend_nxt;
  logic [NUM_SRCS-1:0]            merge_q   [NUM_BANKS];
  logic [NUM_SRCS-1:0]            issue_set [NUM_BANKS];
  logic [NUM_SRCS*DATA_WIDTH-1:0] coll;

  function automatic int bank_of(input logic [NR_BITS-1:0] r);
    return int'(r) % NUM_BANKS;
  endfunction

  // Per bank: lowest pending slot wins; every pending slot naming the same register rides along.
  always_comb begin
    logic               found;
    logic [NR_BITS-1:0] sel;
    found      = 1'b0;
    sel        = '0;
    pend_nxt   = pending;
    bank_valid = '0;
    bank_addr  = '0;
    bank_wid   = '0;
    for (int b = 0; b < NUM_BANKS; b++) issue_set[b] = '0;
    if (state == ISSUE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        found = 1'b0;
        sel   = '0;
        for (int j = 0; j < NUM_SRCS; j++) begin
          if (!found && pending[j] && bank_of(rs_q[j*NR_BITS +: NR_BITS]) == b) begin
            found = 1'b1;
            sel   = rs_q[j*NR_BITS +: NR_BITS];
          end
        end
        if (found) begin
          bank_valid[b]              = 1'b1;
          bank_addr[b*AW +: AW]      = sel[NR_BITS-1:BANK_BITS];
          bank_wid[b*WID_W +: WID_W] = wid_q;
          for (int i = 0; i < NUM_SRCS; i++) begin
            if (pending[i] && rs_q[i*NR_BITS +: NR_BITS] == sel) begin
              issue_set[b][i] = 1'b1;
              pend_nxt[i]     = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (req_mask != '0) ? ISSUE : RSP;
      ISSUE:   if (pend_nxt == '0) state_nxt = WAIT;
      WAIT:    state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wid_q   <= '0;
      rs_q    <= '0;
      pending <= '0;
      coll    <= '0;
      for (int b = 0; b < NUM_BANKS; b++) merge_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) merge_q[b] <= issue_set[b];
      if (state == IDLE && req_valid) begin
        wid_q   <= req_wid;
        rs_q    <= req_rs;
        pending <= req_mask;
        coll    <= '0;
      end else begin
        if (state == ISSUE) pending <= pend_nxt;
        // Data returns one cycle after issue; the recorded merge set says where it lands.
        for (int b = 0; b < NUM_BANKS; b++)
          for (int i = 0; i < NUM_SRCS; i++)
            if (merge_q[b][i]) coll[i*DATA_WIDTH +: DATA_WIDTH] <= bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_wid   = wid_q;
  assign rsp_data  = coll;

endmodule
